// File: rtl/bank_isu_dispatch.sv
// bank_isu_dispatch
//   Oldest-first dispatcher from the bank issue queue into per-channel
//   request slots. It also converts channel read responses into credit
//   release pulses and tracks the number of reads in flight per channel.
//
//   Optional feature macro: BANK_ISU_DISPATCH_STALL_CNT_EN
//     defined   : per-channel 16-bit saturating stall counters
//     undefined : ch_stall_cnt tied to zero
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   iq_valid_array           per-entry valid
//   credit_allow_array       per-entry credit held
//   iq_read_array            per-entry read flag
//   ch_id_flat               entry i channel id at [2i+1:2i]
//   iq_bottom_ptr            oldest entry, start of the selection scan
//   iq_dequeue/_ptr          combinational dispatch pulse and entry
//   ch_req_valid/_ready      per-channel request slot handshake
//   ch_req_ptr/_is_read      slot contents (flattened per channel)
//   ch_rsp_valid             read response completed
//   channels_credit_release  registered response pulse
//   ch_outstanding           reads in flight per channel (4 bits each)
//   dispatch_err             sticky protocol error
//   ch_stall_cnt             stall cycles per channel (16 bits each)
//
// Handshake: a slot presents ch_req_valid and holds ptr/is_read stable
// while valid & ~ready. A transfer happens on a cycle with valid & ready;
// the slot then clears unless a new entry is loaded into it in that cycle.
module bank_isu_dispatch #(
  parameter int CHANNEL_NUM = 3,
  parameter int PTR_WIDTH   = 8,
  localparam int DEPTH      = 1 << PTR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DEPTH-1:0]                 iq_valid_array,
  input  logic [DEPTH-1:0]                 credit_allow_array,
  input  logic [DEPTH-1:0]                 iq_read_array,
  input  logic [2*DEPTH-1:0]               ch_id_flat,
  input  logic [PTR_WIDTH-1:0]             iq_bottom_ptr,
  output logic                             iq_dequeue,
  output logic [PTR_WIDTH-1:0]             iq_dequeue_ptr,
  output logic [CHANNEL_NUM-1:0]           ch_req_valid,
  input  logic [CHANNEL_NUM-1:0]           ch_req_ready,
  output logic [CHANNEL_NUM*PTR_WIDTH-1:0] ch_req_ptr,
  output logic [CHANNEL_NUM-1:0]           ch_req_is_read,
  input  logic [CHANNEL_NUM-1:0]           ch_rsp_valid,
  output logic [CHANNEL_NUM-1:0]           channels_credit_release,
  output logic [CHANNEL_NUM*4-1:0]         ch_outstanding,
  output logic                             dispatch_err,
  output logic [CHANNEL_NUM*16-1:0]        ch_stall_cnt
);

  logic [CHANNEL_NUM-1:0] req_valid_q;
  logic [CHANNEL_NUM-1:0] req_read_q;
  logic [PTR_WIDTH-1:0]   req_ptr_q [CHANNEL_NUM];
  logic [3:0]             out_q     [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] release_q;
  logic                   err_q;
  logic [PTR_WIDTH-1:0]   last_ptr_q;
  logic                   last_vld_q;

  logic [CHANNEL_NUM-1:0] slot_free;
  logic [3:0]             slot_free_ext;
  logic [CHANNEL_NUM-1:0] rd_hs;
  logic                   sel_found;
  logic [PTR_WIDTH-1:0]   sel_ptr;
  logic [1:0]             sel_id;
  logic                   bad_hit;
  logic [PTR_WIDTH-1:0]   idx;
  logic [1:0]             id;
  logic                   eligible;
  logic                   err_d;

  // A slot draining this cycle may be reloaded in the same cycle.
  assign slot_free     = ~req_valid_q | ch_req_ready;
  assign slot_free_ext = 4'(slot_free);
  assign rd_hs         = req_valid_q & ch_req_ready & req_read_q;

  // Rotating scan from the bottom pointer. The entry dispatched last cycle
  // is masked because the queue only clears its valid at the next edge.
  // An eligible entry with an out-of-range channel id flags an error and
  // is skipped so younger entries can still be dispatched.
  always_comb begin
    sel_found = 1'b0;
    sel_ptr   = '0;
    sel_id    = '0;
    bad_hit   = 1'b0;
    idx       = '0;
    id        = '0;
    eligible  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx      = iq_bottom_ptr + PTR_WIDTH'(k);
      id       = ch_id_flat[2*idx +: 2];
      eligible = iq_valid_array[idx] & credit_allow_array[idx] &
                 ~(last_vld_q & (idx == last_ptr_q));
      if (!sel_found && eligible) begin
        if (int'(id) >= CHANNEL_NUM) begin
          bad_hit = 1'b1;
        end else if (slot_free_ext[id]) begin
          sel_found = 1'b1;
          sel_ptr   = idx;
          sel_id    = id;
        end
      end
    end
  end

  assign iq_dequeue     = sel_found;
  assign iq_dequeue_ptr = sel_ptr;

  always_comb begin
    err_d = err_q | bad_hit;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (ch_rsp_valid[c] && out_q[c] == 4'd0) err_d = 1'b1;
      if (rd_hs[c] && out_q[c] == 4'd8)        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_q <= '0;
      req_read_q  <= '0;
      release_q   <= '0;
      err_q       <= 1'b0;
      last_ptr_q  <= '0;
      last_vld_q  <= 1'b0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        req_ptr_q[c] <= '0;
        out_q[c]     <= '0;
      end
    end else begin
      release_q  <= ch_rsp_valid;
      err_q      <= err_d;
      last_ptr_q <= sel_ptr;
      last_vld_q <= sel_found;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        if (sel_found && int'(sel_id) == c) begin
          req_valid_q[c] <= 1'b1;
          req_ptr_q[c]   <= sel_ptr;
          req_read_q[c]  <= iq_read_array[sel_ptr];
        end else if (ch_req_ready[c]) begin
          req_valid_q[c] <= 1'b0;
        end
        // Simultaneous increment and decrement cancel; both ends saturate.
        if (rd_hs[c] && !ch_rsp_valid[c] && out_q[c] != 4'd8) begin
          out_q[c] <= out_q[c] + 4'd1;
        end else if (ch_rsp_valid[c] && !rd_hs[c] && out_q[c] != 4'd0) begin
          out_q[c] <= out_q[c] - 4'd1;
        end
      end
    end
  end

`ifdef BANK_ISU_DISPATCH_STALL_CNT_EN
  logic [15:0] stall_q [CHANNEL_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNEL_NUM; c++) stall_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        if (req_valid_q[c] && !ch_req_ready[c] && stall_q[c] != 16'hFFFF) begin
          stall_q[c] <= stall_q[c] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_stall
    assign ch_stall_cnt[g*16 +: 16] = stall_q[g];
  end
`else
  assign ch_stall_cnt = '0;
`endif

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_out
    assign ch_req_ptr[g*PTR_WIDTH +: PTR_WIDTH] = req_ptr_q[g];
    assign ch_outstanding[g*4 +: 4]             = out_q[g];
  end

  assign ch_req_valid            = req_valid_q;
  assign ch_req_is_read          = req_read_q;
  assign channels_credit_release = release_q;
  assign dispatch_err            = err_q;

endmodule

// File: tb/tb_bank_isu_dispatch.sv
module tb_bank_isu_dispatch;
  localparam int CN    = 3;
  localparam int PW    = 8;
  localparam int DEPTH = 1 << PW;

  logic              clk;
  logic              rst;
  logic [DEPTH-1:0]  iq_valid_array;
  logic [DEPTH-1:0]  credit_allow_array;
  logic [DEPTH-1:0]  iq_read_array;
  logic [2*DEPTH-1:0] ch_id_flat;
  logic [PW-1:0]     iq_bottom_ptr;
  logic              iq_dequeue;
  logic [PW-1:0]     iq_dequeue_ptr;
  logic [CN-1:0]     ch_req_valid;
  logic [CN-1:0]     ch_req_ready;
  logic [CN*PW-1:0]  ch_req_ptr;
  logic [CN-1:0]     ch_req_is_read;
  logic [CN-1:0]     ch_rsp_valid;
  logic [CN-1:0]     channels_credit_release;
  logic [CN*4-1:0]   ch_outstanding;
  logic              dispatch_err;
  logic [CN*16-1:0]  ch_stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_ptr;
  logic [15:0]   exp_stall;

  bank_isu_dispatch #(.CHANNEL_NUM(CN), .PTR_WIDTH(PW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .iq_valid_array          (iq_valid_array),
    .credit_allow_array      (credit_allow_array),
    .iq_read_array           (iq_read_array),
    .ch_id_flat              (ch_id_flat),
    .iq_bottom_ptr           (iq_bottom_ptr),
    .iq_dequeue              (iq_dequeue),
    .iq_dequeue_ptr          (iq_dequeue_ptr),
    .ch_req_valid            (ch_req_valid),
    .ch_req_ready            (ch_req_ready),
    .ch_req_ptr              (ch_req_ptr),
    .ch_req_is_read          (ch_req_is_read),
    .ch_rsp_valid            (ch_rsp_valid),
    .channels_credit_release (channels_credit_release),
    .ch_outstanding          (ch_outstanding),
    .dispatch_err            (dispatch_err),
    .ch_stall_cnt            (ch_stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int i, input logic v, input logic cr,
                           input logic rd, input logic [1:0] ch);
    iq_valid_array[i]     = v;
    credit_allow_array[i] = cr;
    iq_read_array[i]      = rd;
    ch_id_flat[2*i +: 2]  = ch;
  endtask

  // Dispatch one read on channel ch through entry e and let it hand shake.
  task automatic read_txn(input int e, input logic [1:0] ch);
    set_entry(e, 1'b1, 1'b1, 1'b1, ch);
    tick();
    set_entry(e, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
  endtask

  initial begin
    rst                = 1'b1;
    iq_valid_array     = '0;
    credit_allow_array = '0;
    iq_read_array      = '0;
    ch_id_flat         = '0;
    iq_bottom_ptr      = 8'd5;
    ch_req_ready       = '0;
    ch_rsp_valid       = '0;
    #12;
    check("rst_dequeue",  {63'd0, iq_dequeue}, 64'd0);
    check("rst_req_valid", {61'd0, ch_req_valid}, 64'd0);
    check("rst_req_ptr",  {40'd0, ch_req_ptr}, 64'd0);
    check("rst_out",      {52'd0, ch_outstanding}, 64'd0);
    check("rst_release",  {61'd0, channels_credit_release}, 64'd0);
    check("rst_err",      {63'd0, dispatch_err}, 64'd0);
    check("rst_stall",    {16'd0, ch_stall_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Oldest-first with wrap: bottom=5, entries 3 and 7 on ch0
    ch_req_ready = 3'b111;
    set_entry(3, 1'b1, 1'b1, 1'b0, 2'd0);
    set_entry(7, 1'b1, 1'b1, 1'b0, 2'd0);
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd3);
    #1;
    exp_ptr = exp_q.pop_front();
    check("t1_deq0", {63'd0, iq_dequeue}, 64'd1);
    check("t1_ptr0", {56'd0, iq_dequeue_ptr}, {56'd0, exp_ptr});
    tick();
    set_entry(7, 1'b0, 1'b0, 1'b0, 2'd0);
    check("t1_slot_v", {61'd0, ch_req_valid}, 64'b001);
    check("t1_slot_ptr", {56'd0, ch_req_ptr[7:0]}, 64'd7);
    check("t1_slot_rd", {61'd0, ch_req_is_read}, 64'd0);
    #1;
    exp_ptr = exp_q.pop_front();
    check("t1_deq1", {63'd0, iq_dequeue}, 64'd1);
    check("t1_ptr1", {56'd0, iq_dequeue_ptr}, {56'd0, exp_ptr});
    tick();
    set_entry(3, 1'b0, 1'b0, 1'b0, 2'd0);
    check("t1_slot_ptr2", {56'd0, ch_req_ptr[7:0]}, 64'd3);
    #1;
    check("t1_idle", {63'd0, iq_dequeue}, 64'd0);
    tick();
    check("t1_drained", {61'd0, ch_req_valid}, 64'd0);

    // Credit gating on entry 10
    set_entry(10, 1'b1, 1'b0, 1'b0, 2'd0);
    #1;
    check("t2_nocredit", {63'd0, iq_dequeue}, 64'd0);
    tick();
    check("t2_nocredit2", {63'd0, iq_dequeue}, 64'd0);
    credit_allow_array[10] = 1'b1;
    #1;
    check("t2_deq", {63'd0, iq_dequeue}, 64'd1);
    check("t2_ptr", {56'd0, iq_dequeue_ptr}, 64'd10);
    tick();
    set_entry(10, 1'b0, 1'b0, 1'b0, 2'd0);
    check("t2_slot_v", {63'd0, ch_req_valid[0]}, 64'd1);
    check("t2_slot_ptr", {56'd0, ch_req_ptr[7:0]}, 64'd10);
    tick();

    // Backpressure on ch1, then seamless reload
    ch_req_ready[1] = 1'b0;
    set_entry(15, 1'b1, 1'b1, 1'b0, 2'd1);
    #1;
    check("t3_deq15", {56'd0, iq_dequeue_ptr}, 64'd15);
    tick();
    set_entry(15, 1'b0, 1'b0, 1'b0, 2'd0);
    set_entry(20, 1'b1, 1'b1, 1'b0, 2'd1);
    #1;
    check("t3_blocked", {63'd0, iq_dequeue}, 64'd0);
    tick();
    check("t3_blocked2", {63'd0, iq_dequeue}, 64'd0);
    check("t3_hold_ptr", {56'd0, ch_req_ptr[15:8]}, 64'd15);
    ch_req_ready[1] = 1'b1;
    #1;
    check("t3_deq", {63'd0, iq_dequeue}, 64'd1);
    check("t3_ptr", {56'd0, iq_dequeue_ptr}, 64'd20);
    tick();
    set_entry(20, 1'b0, 1'b0, 1'b0, 2'd0);
    check("t3_reload_v", {63'd0, ch_req_valid[1]}, 64'd1);
    check("t3_reload_ptr", {56'd0, ch_req_ptr[15:8]}, 64'd20);
    tick();
    check("t3_drained", {63'd0, ch_req_valid[1]}, 64'd0);

    // Eight reads on ch2, then a ninth
    for (int k = 0; k < 8; k++) begin
      read_txn(30 + k, 2'd2);
      if (k == 0) check("t4_out1", {60'd0, ch_outstanding[11:8]}, 64'd1);
    end
    check("t4_out8", {60'd0, ch_outstanding[11:8]}, 64'd8);
    check("t4_no_err", {63'd0, dispatch_err}, 64'd0);
    set_entry(40, 1'b1, 1'b1, 1'b1, 2'd2);
    tick();
    set_entry(40, 1'b0, 1'b0, 1'b0, 2'd0);
    check("t4_is_read", {63'd0, ch_req_is_read[2]}, 64'd1);
    tick();
    check("t4_err", {63'd0, dispatch_err}, 64'd1);
    check("t4_sat", {60'd0, ch_outstanding[11:8]}, 64'd8);
    ch_rsp_valid[2] = 1'b1;
    #1;
    check("t4_rel_pre", {63'd0, channels_credit_release[2]}, 64'd0);
    tick();
    ch_rsp_valid[2] = 1'b0;
    check("t4_release", {63'd0, channels_credit_release[2]}, 64'd1);
    check("t4_out7", {60'd0, ch_outstanding[11:8]}, 64'd7);
    tick();
    check("t4_rel_end", {63'd0, channels_credit_release[2]}, 64'd0);

    // Simultaneous read handshake and response on ch0
    read_txn(41, 2'd0);
    check("t5_out1", {60'd0, ch_outstanding[3:0]}, 64'd1);
    set_entry(42, 1'b1, 1'b1, 1'b1, 2'd0);
    tick();
    set_entry(42, 1'b0, 1'b0, 1'b0, 2'd0);
    ch_rsp_valid[0] = 1'b1;
    tick();
    ch_rsp_valid[0] = 1'b0;
    check("t5_out_same", {60'd0, ch_outstanding[3:0]}, 64'd1);
    check("t5_release", {63'd0, channels_credit_release[0]}, 64'd1);

    // Stall ch0 for five cycles, then reset mid-stall
    ch_req_ready[0] = 1'b0;
    set_entry(60, 1'b1, 1'b1, 1'b0, 2'd0);
    tick();
    set_entry(60, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (5) tick();
`ifdef BANK_ISU_DISPATCH_STALL_CNT_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    check("t6_stall", {48'd0, ch_stall_cnt[15:0]}, {48'd0, exp_stall});
    check("t6_stalled_v", {63'd0, ch_req_valid[0]}, 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_v", {61'd0, ch_req_valid}, 64'd0);
    check("t6_rst_ptr", {40'd0, ch_req_ptr}, 64'd0);
    check("t6_rst_rd", {61'd0, ch_req_is_read}, 64'd0);
    check("t6_rst_out", {52'd0, ch_outstanding}, 64'd0);
    check("t6_rst_rel", {61'd0, channels_credit_release}, 64'd0);
    check("t6_rst_err", {63'd0, dispatch_err}, 64'd0);
    check("t6_rst_stall", {16'd0, ch_stall_cnt}, 64'd0);
    check("t6_rst_deq", {63'd0, iq_dequeue}, 64'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Out-of-range channel id: flagged, skipped, younger entry dispatched
    ch_req_ready = 3'b111;
    set_entry(70, 1'b1, 1'b1, 1'b0, 2'd3);
    set_entry(71, 1'b1, 1'b1, 1'b0, 2'd0);
    #1;
    check("t7_deq", {63'd0, iq_dequeue}, 64'd1);
    check("t7_ptr", {56'd0, iq_dequeue_ptr}, 64'd71);
    tick();
    set_entry(71, 1'b0, 1'b0, 1'b0, 2'd0);
    check("t7_err", {63'd0, dispatch_err}, 64'd1);
    check("t7_slot_ptr", {56'd0, ch_req_ptr[7:0]}, 64'd71);
    #1;
    check("t7_bad_never", {63'd0, iq_dequeue}, 64'd0);
    tick();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
